obi_sbr_sram: RTL and testbench

// - OBI subordinate endpoint: flop-based word memory behind one crossbar output port (Foo/Bar slot).
// - Accepts address-phase requests, performs reads/byte-masked writes, and returns responses in order.
// - Buffers responses so the manager can stall with rready_i (UseRReady=1, CombGnt=0 config).

---
 rtl/obi_sbr_sram.sv | 161 ++++++++++++++++
 tb/tb_obi_sbr_sram.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obi_sbr_sram.sv
// obi_sbr_sram: OBI subordinate backed by a flop-based word memory.
// Requests are accepted in the address phase and answered in order from a
// small response FIFO, so the manager can stall responses with rready_i.
// Optional feature macro: OBI_SBR_RO_EN makes the lowest RoWords words
// read-only (writes there are dropped and answered with err_o=1).
module obi_sbr_sram #(
    parameter int unsigned NumWords  = 256,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned IdWidth   = 1,
    parameter int unsigned RspDepth  = 2,
    parameter int unsigned RoWords   = 0
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   req_i,
    input  logic [AddrWidth-1:0]   addr_i,
    input  logic                   we_i,
    input  logic [DataWidth/8-1:0] be_i,
    input  logic [DataWidth-1:0]   wdata_i,
    input  logic [IdWidth-1:0]     aid_i,
    output logic                   gnt_o,
    output logic                   rvalid_o,
    input  logic                   rready_i,
    output logic [DataWidth-1:0]   rdata_o,
    output logic [IdWidth-1:0]     rid_o,
    output logic                   err_o
);

    localparam int unsigned IdxW = $clog2(NumWords);
    localparam int unsigned PtrW = (RspDepth > 1) ? $clog2(RspDepth) : 1;
    localparam int unsigned CntW = $clog2(RspDepth + 1);
    localparam int unsigned BeW  = DataWidth / 8;

    localparam logic [AddrWidth-1:0] NumWordsA = AddrWidth'(NumWords);
    localparam logic [CntW-1:0]      DepthC    = CntW'(RspDepth);
    localparam logic [PtrW-1:0]      LastPtr   = PtrW'(RspDepth - 1);

    // Elaboration-time parameter sanity checks.
    if (NumWords < 2 || RspDepth < 1 || RoWords > NumWords) begin : g_bad_params
        $error("obi_sbr_sram: illegal NumWords/RspDepth/RoWords");
    end

    logic [DataWidth-1:0] mem_q [NumWords];
    logic [DataWidth-1:0] mem_d [NumWords];

    logic [DataWidth-1:0] fifo_rdata_q [RspDepth];
    logic [DataWidth-1:0] fifo_rdata_d [RspDepth];
    logic [IdWidth-1:0]   fifo_rid_q   [RspDepth];
    logic [IdWidth-1:0]   fifo_rid_d   [RspDepth];
    logic                 fifo_err_q   [RspDepth];
    logic                 fifo_err_d   [RspDepth];

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    logic [IdxW-1:0]      idx;
    logic                 addr_err;
    logic                 ro_err;
    logic                 req_err;
    logic                 accept;
    logic                 pop;
    logic [DataWidth-1:0] rsp_rdata;

    // Handshake: a request is accepted on a rising edge where req_i & gnt_o;
    // a response is retired on a rising edge where rvalid_o & rready_i.
    // Grant only looks at the registered fill level, so rready_i never
    // reaches gnt_o combinationally.
    assign gnt_o    = req_i & (count_q < DepthC);
    assign accept   = req_i & gnt_o;
    assign rvalid_o = (count_q != '0);
    assign pop      = rvalid_o & rready_i;

    assign idx      = addr_i[IdxW+1:2];
    assign addr_err = (addr_i[1:0] != 2'b00) || ((addr_i >> 2) >= NumWordsA);

`ifdef OBI_SBR_RO_EN
    // Writes into the low read-only window are refused.
    assign ro_err = we_i && (int'(idx) < int'(RoWords));
`else
    assign ro_err = 1'b0;
`endif

    assign req_err   = addr_err | ro_err;
    assign rsp_rdata = (!we_i && !req_err) ? mem_q[idx] : '0;

    // Memory next state: byte-masked write for accepted, error-free writes.
    always_comb begin
        mem_d = mem_q;
        if (accept && we_i && !req_err) begin
            for (int k = 0; k < BeW; k++) begin
                if (be_i[k]) begin
                    mem_d[idx][8*k +: 8] = wdata_i[8*k +: 8];
                end
            end
        end
    end

    // Response FIFO next state: push on accept, pop on response handshake.
    always_comb begin
        fifo_rdata_d = fifo_rdata_q;
        fifo_rid_d   = fifo_rid_q;
        fifo_err_d   = fifo_err_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        if (accept) begin
            fifo_rdata_d[wr_ptr_q] = rsp_rdata;
            fifo_rid_d[wr_ptr_q]   = aid_i;
            fifo_err_d[wr_ptr_q]   = req_err;
            wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
        end
        if (accept && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!accept && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // State registers; reset clears memory and discards pending responses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumWords; i++) begin
                mem_q[i] <= '0;
            end
            for (int j = 0; j < RspDepth; j++) begin
                fifo_rdata_q[j] <= '0;
                fifo_rid_q[j]   <= '0;
                fifo_err_q[j]   <= 1'b0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q        <= mem_d;
            fifo_rdata_q <= fifo_rdata_d;
            fifo_rid_q   <= fifo_rid_d;
            fifo_err_q   <= fifo_err_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    // Response outputs come from the FIFO head and are zero when empty.
    always_comb begin
        rdata_o = '0;
        rid_o   = '0;
        err_o   = 1'b0;
        if (rvalid_o) begin
            rdata_o = fifo_rdata_q[rd_ptr_q];
            rid_o   = fifo_rid_q[rd_ptr_q];
            err_o   = fifo_err_q[rd_ptr_q];
        end
    end

endmodule

// File: tb/tb_obi_sbr_sram.sv
// tb_obi_sbr_sram: randomized and directed bench for obi_sbr_sram against
// a word-array reference model with an in-order expected response queue.
module tb_obi_sbr_sram;

    localparam int RO_WORDS = 4;

    logic        clk;
    logic        rst_n;
    logic        req_i;
    logic [31:0] addr_i;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] wdata_i;
    logic        aid_i;
    logic        gnt_o;
    logic        rvalid_o;
    logic        rready_i;
    logic [31:0] rdata_o;
    logic        rid_o;
    logic        err_o;

    int n_checks = 0;
    int n_pass   = 0;

    // Response tuples packed as {rdata, rid, err}.
    logic [33:0] exp_q[$];
    logic [33:0] obs_q[$];
    logic [31:0] model_mem [256];

    bit rand_rready = 0;
    bit rready_set  = 1;

    obi_sbr_sram #(
        .NumWords (256),
        .AddrWidth(32),
        .DataWidth(32),
        .IdWidth  (1),
        .RspDepth (2),
        .RoWords  (RO_WORDS)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .req_i   (req_i),
        .addr_i  (addr_i),
        .we_i    (we_i),
        .be_i    (be_i),
        .wdata_i (wdata_i),
        .aid_i   (aid_i),
        .gnt_o   (gnt_o),
        .rvalid_o(rvalid_o),
        .rready_i(rready_i),
        .rdata_o (rdata_o),
        .rid_o   (rid_o),
        .err_o   (err_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // rready driver: random when enabled, otherwise the value tests request.
    always @(posedge clk) begin
        #2;
        rready_i = rand_rready ? ($urandom_range(0, 3) != 0) : rready_set;
    end

    // Response recorder: every retired response, in order.
    always @(negedge clk) begin
        if (rst_n && rvalid_o && rready_i) obs_q.push_back({rdata_o, rid_o, err_o});
    end

    // ---------------- reference model ----------------
    function automatic void model_clear();
        for (int i = 0; i < 256; i++) model_mem[i] = 32'h0;
    endfunction

    function automatic void model_accept(input logic we, input logic [31:0] addr,
                                         input logic [3:0] be, input logic [31:0] wd,
                                         input logic id);
        int unsigned w;
        bit          err;
        logic [31:0] mask;
        logic [31:0] rd;
        w   = addr / 4;
        err = (addr % 4 != 0) || (w >= 256);
`ifdef OBI_SBR_RO_EN
        if (we && !err && w < RO_WORDS) err = 1;
`endif
        rd = 32'h0;
        if (!err) begin
            if (we) begin
                mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
                model_mem[w] = (model_mem[w] & ~mask) | (wd & mask);
            end else begin
                rd = model_mem[w];
            end
        end
        exp_q.push_back({rd, id, err});
    endfunction

    // ---------------- driver tasks (start/end at posedge+1) ----------------
    task automatic issue(input logic we, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wd, input logic id);
        bit got;
        got     = 0;
        req_i   = 1'b1;
        we_i    = we;
        addr_i  = addr;
        be_i    = be;
        wdata_i = wd;
        aid_i   = id;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (gnt_o) begin
                got = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (got) begin
            @(posedge clk);
            model_accept(we, addr, be, wd, id);
            #1;
        end else begin
            n_checks++;
            $display("FAIL issue_grant: no grant within 64 cycles for addr %h", addr);
        end
        req_i = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 400; c++) begin
            if (obs_q.size() >= exp_q.size() && !rvalid_o) break;
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; req_i = 1'b0; addr_i = '0; we_i = 1'b0; be_i = '0;
        wdata_i = '0; aid_i = 1'b0; rready_set = 1;
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (rvalid_o !== 1'b0) $display("FAIL reset_rvalid: got %b want 0", rvalid_o); else n_pass++;
        n_checks++; if (rdata_o !== 32'h0) $display("FAIL reset_rdata: got %h want 0", rdata_o); else n_pass++;
        n_checks++; if (rid_o !== 1'b0) $display("FAIL reset_rid: got %b want 0", rid_o); else n_pass++;
        n_checks++; if (err_o !== 1'b0) $display("FAIL reset_err: got %b want 0", err_o); else n_pass++;
        n_checks++; if (gnt_o !== 1'b0) $display("FAIL reset_gnt: got %b want 0", gnt_o); else n_pass++;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_latency();
        req_i = 1'b1; we_i = 1'b0; addr_i = 32'h40; be_i = 4'h0; aid_i = 1'b1;
        @(negedge clk);
        n_checks++; if (gnt_o !== 1'b1) $display("FAIL latency_gnt: got %b want 1", gnt_o); else n_pass++;
        n_checks++; if (rvalid_o !== 1'b0) $display("FAIL latency_no_comb_rvalid: got %b want 0", rvalid_o); else n_pass++;
        @(posedge clk);
        model_accept(1'b0, 32'h40, 4'h0, 32'h0, 1'b1);
        #1;
        req_i = 1'b0;
        @(negedge clk);
        n_checks++; if (rvalid_o !== 1'b1) $display("FAIL latency_rvalid: got %b want 1", rvalid_o); else n_pass++;
        @(posedge clk);
        #1;
        wait_drain();
        n_checks++;
        if (obs_q.size() !== exp_q.size()) $display("FAIL latency_count: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
        while (exp_q.size() > 0) begin
            logic [33:0] e, o;
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
            n_checks++;
            if (o !== e) $display("FAIL latency_rsp: got %h want %h", o, e); else n_pass++;
        end
        obs_q.delete();
    endtask

    task automatic test_directed();
        issue(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b0);
        issue(1'b0, 32'h10, 4'h0, 32'h0, 1'b1);
        issue(1'b1, 32'h10, 4'b0101, 32'h11223344, 1'b1);
        issue(1'b0, 32'h10, 4'h0, 32'h0, 1'b0);
        issue(1'b1, 32'h14, 4'h0, 32'hFFFFFFFF, 1'b0);   // be=0 no-op
        issue(1'b0, 32'h14, 4'h0, 32'h0, 1'b1);
        issue(1'b1, 32'h08, 4'hF, 32'hA5A5A5A5, 1'b0);   // read-only window when enabled
        issue(1'b0, 32'h08, 4'h0, 32'h0, 1'b1);
        issue(1'b1, 32'h20, 4'hF, 32'h0BADF00D, 1'b0);
        issue(1'b0, 32'h20, 4'h0, 32'h0, 1'b0);          // write at N, read at N+1
        wait_drain();
        n_checks++;
        if (obs_q.size() !== exp_q.size()) $display("FAIL directed_count: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
        n_checks++;
        if (obs_q.size() > 3 && obs_q[3][33:2] !== 32'hDE22BE44) $display("FAIL directed_bytemask: got %h want de22be44", obs_q[3][33:2]); else n_pass++;
        while (exp_q.size() > 0) begin
            logic [33:0] e, o;
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
            n_checks++;
            if (o !== e) $display("FAIL directed_rsp: got %h want %h", o, e); else n_pass++;
        end
        obs_q.delete();
    endtask

    task automatic test_errors();
        issue(1'b1, 32'h0, 4'hF, 32'h12345678, 1'b0);
        issue(1'b0, 32'h400, 4'h0, 32'h0, 1'b1);
        issue(1'b0, 32'h2, 4'h0, 32'h0, 1'b0);
        issue(1'b1, 32'h400, 4'hF, 32'hFFFFFFFF, 1'b1);  // would alias word 0
        issue(1'b1, 32'h11, 4'hF, 32'hFFFFFFFF, 1'b0);   // misaligned write
        issue(1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
        issue(1'b0, 32'h10, 4'h0, 32'h0, 1'b0);
        issue(1'b0, 32'h8000_0000, 4'h0, 32'h0, 1'b1);
        wait_drain();
        n_checks++;
        if (obs_q.size() !== exp_q.size()) $display("FAIL errors_count: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
        while (exp_q.size() > 0) begin
            logic [33:0] e, o;
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
            n_checks++;
            if (o !== e) $display("FAIL errors_rsp: got %h want %h", o, e); else n_pass++;
        end
        obs_q.delete();
    endtask

    task automatic test_backpressure();
        logic [33:0] head;
        rready_set = 0;
        issue(1'b0, 32'h10, 4'h0, 32'h0, 1'b0);
        issue(1'b0, 32'h20, 4'h0, 32'h0, 1'b1);
        head = exp_q[0];
        req_i = 1'b1; we_i = 1'b0; addr_i = 32'h14; aid_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++; if (gnt_o !== 1'b0) $display("FAIL bp_gnt_full: got %b want 0", gnt_o); else n_pass++;
            n_checks++; if (rvalid_o !== 1'b1) $display("FAIL bp_rvalid_hold: got %b want 1", rvalid_o); else n_pass++;
            n_checks++;
            if ({rdata_o, rid_o, err_o} !== head) $display("FAIL bp_stable: got %h want %h", {rdata_o, rid_o, err_o}, head); else n_pass++;
            @(posedge clk);
            #1;
        end
        req_i = 1'b0;                                    // request dropped without grant
        idle(1);
        req_i = 1'b1;
        rready_set = 1;
        @(negedge clk);
        n_checks++; if (gnt_o !== 1'b0) $display("FAIL bp_gnt_full_rready: got %b want 0", gnt_o); else n_pass++;
        @(posedge clk);
        #1;
        issue(1'b0, 32'h14, 4'h0, 32'h0, 1'b0);
        wait_drain();
        n_checks++;
        if (obs_q.size() !== exp_q.size()) $display("FAIL bp_count: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
        while (exp_q.size() > 0) begin
            logic [33:0] e, o;
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
            n_checks++;
            if (o !== e) $display("FAIL bp_rsp_order: got %h want %h", o, e); else n_pass++;
        end
        obs_q.delete();
    endtask

    task automatic test_random();
        logic [31:0] addr;
        int          r;
        rand_rready = 1;
        for (int t = 0; t < 300; t++) begin
            r = $urandom_range(0, 19);
            if (r == 0) addr = ($urandom_range(0, 15) * 4) + $urandom_range(1, 3);
            else if (r == 1) addr = 32'h400 + $urandom_range(0, 1023) * 4;
            else if (r == 2) addr = $urandom & 32'hFFFF_FFFC;
            else addr = $urandom_range(0, 15) * 4;
            issue($urandom_range(0, 1) == 1, addr, 4'($urandom_range(0, 15)), $urandom, $urandom_range(0, 1) == 1);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        rand_rready = 0;
        rready_set  = 1;
        wait_drain();
        n_checks++;
        if (obs_q.size() !== exp_q.size()) $display("FAIL random_count: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
        while (exp_q.size() > 0) begin
            logic [33:0] e, o;
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
            n_checks++;
            if (o !== e) $display("FAIL random_rsp: got %h want %h", o, e); else n_pass++;
        end
        obs_q.delete();
    endtask

    task automatic test_reset_mid();
        issue(1'b1, 32'h30, 4'hF, 32'hCAFEF00D, 1'b0);
        wait_drain();
        exp_q.delete();
        obs_q.delete();
        rready_set = 0;
        issue(1'b0, 32'h30, 4'h0, 32'h0, 1'b0);
        issue(1'b0, 32'h30, 4'h0, 32'h0, 1'b1);
        rst_n = 1'b0;
        #1;
        n_checks++; if (rvalid_o !== 1'b0) $display("FAIL midreset_rvalid: got %b want 0", rvalid_o); else n_pass++;
        n_checks++; if (rdata_o !== 32'h0) $display("FAIL midreset_rdata: got %h want 0", rdata_o); else n_pass++;
        exp_q.delete();
        obs_q.delete();
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        rready_set = 1;
        @(posedge clk);
        #1;
        issue(1'b0, 32'h30, 4'h0, 32'h0, 1'b1);
        wait_drain();
        n_checks++;
        if (obs_q.size() !== exp_q.size()) $display("FAIL midreset_count: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
        while (exp_q.size() > 0) begin
            logic [33:0] e, o;
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
            n_checks++;
            if (o !== e) $display("FAIL midreset_reread: got %h want %h", o, e); else n_pass++;
        end
        obs_q.delete();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rready_i = 1'b1;
        test_reset();
        test_latency();
        test_directed();
        test_errors();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
